// File: rtl/apb_requester_pkg.sv
// rtl/apb_requester_pkg.sv - shared debugger APB types, widths and register map
package apb_requester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam int APB_ADDR_W = 5;
    localparam int APB_DATA_W = 8;

    localparam logic [APB_ADDR_W-1:0] REG_STATUS_ADDR     = 5'h00;
    localparam logic [APB_ADDR_W-1:0] REG_CONTROL_ADDR    = 5'h01;
    localparam logic [APB_ADDR_W-1:0] REG_MEM_WINDOW_ADDR = 5'h10;

    // A zero timeout still needs a one-bit counter so the port widths stay legal.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_requester_if.sv
// rtl/apb_requester_if.sv - command/response channels plus APB bus of the debugger requester
interface apb_requester_if #(
    parameter int ADDR_W = apb_requester_pkg::APB_ADDR_W,
    parameter int DATA_W = apb_requester_pkg::APB_DATA_W
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [DATA_W-1:0] CMD_WDATA;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_ERR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY, PRDATA, PREADY,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - clearable ACCESS wait counter with timeout-reached flag
module apb_wait_timer import apb_requester_pkg::*; #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);
    localparam int CNT_W = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] r_count;

    // o_expire marks the TIMEOUT-th stalled cycle, so the abort lands on that same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (TIMEOUT != 0) && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (TIMEOUT != 0) && (r_count == LAST);

endmodule

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - single-outstanding APB initiator for the debug transport
module apb_requester import apb_requester_pkg::*; #(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic PCLK,
    input  logic PRESET,
    apb_requester_if.master bus
);
    apb_state_t        r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;

    logic w_timer_clear;
    logic w_timer_inc;
    logic w_timeout;

    assign w_timer_clear = (r_state == ST_SETUP);
    assign w_timer_inc   = (r_state == ST_ACCESS) && !bus.PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk    (PCLK),
        .i_rst    (PRESET),
        .i_clear  (w_timer_clear),
        .i_inc    (w_timer_inc),
        .o_expire (w_timeout)
    );

    // PREADY is tested before the timeout so a late ready still completes normally.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.CMD_VALID) begin
                        r_pwrite    <= bus.CMD_WRITE;
                        r_paddr     <= bus.CMD_ADDR;
                        r_pwdata    <= bus.CMD_WRITE ? bus.CMD_WDATA : '0;
                        r_psel      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.PREADY) begin
                        r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
                        r_rsp_err   <= 1'b0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CMD_READY = r_cmd_ready;
    assign bus.RSP_VALID = r_rsp_valid;
    assign bus.RSP_RDATA = r_rsp_rdata;
    assign bus.RSP_ERR   = r_rsp_err;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - self-checking bench for apb_requester
module tb_apb_requester;
    import apb_requester_pkg::*;

    localparam int TMO = 15;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_requester_if #(.ADDR_W(5), .DATA_W(8)) bus ();
    apb_requester_if #(.ADDR_W(5), .DATA_W(8)) bus0 ();

    apb_requester #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(TMO)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));
    apb_requester #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(0))   dut0 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus0));

    int checks = 0;
    int errors = 0;

    // status-register completer: bit 0 write toggles debug-request on each PENABLE rise
    bit   dbg_req = 1'b0;
    int   toggles = 0;
    int   low_run = 0;
    int   last_gap = 0;
    logic prev_pen = 1'b0;

    always @(negedge PCLK) begin
        if (bus.PENABLE === 1'b1) begin
            if (prev_pen !== 1'b1) last_gap = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
        if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1 && prev_pen !== 1'b1 && bus.PWRITE === 1'b1 &&
            bus.PADDR === REG_STATUS_ADDR && bus.PWDATA[0] === 1'b1) begin
            dbg_req = !dbg_req;
            toggles++;
        end
        prev_pen = bus.PENABLE;
    end

    function automatic int exp_access(input int waits);
        return (TMO != 0 && waits >= TMO) ? TMO : waits + 1;
    endfunction

    function automatic bit exp_err(input int waits);
        return (TMO != 0 && waits >= TMO);
    endfunction

    bit          t_acc, t_got, t_bus_ok, t_hold_ok, t_done_ok;
    int          t_lat, t_nsel, t_nen;
    logic [7:0]  t_rdata;
    logic        t_err;

    task automatic do_txn(input bit wr, input logic [4:0] addr, input logic [7:0] wdata, input int waits,
                          input logic [7:0] prdata, input int hold, input bit keep_valid);
        logic rdy;
        int   acnt;
        t_acc = 0; t_got = 0; t_lat = 0; t_nsel = 0; t_nen = 0; t_rdata = '0; t_err = 1'b0;
        t_bus_ok = 1; t_hold_ok = 1; t_done_ok = 0; acnt = 0;
        bus.CMD_VALID = 1'b1; bus.CMD_WRITE = wr; bus.CMD_ADDR = addr; bus.CMD_WDATA = wdata; bus.RSP_READY = 1'b0;
        for (int c = 0; c < 20 && !t_acc; c++) begin
            rdy = bus.CMD_READY;
            @(posedge PCLK); @(negedge PCLK);
            if (rdy === 1'b1) t_acc = 1;
        end
        if (keep_valid) begin
            bus.CMD_WRITE = 1'($urandom); bus.CMD_ADDR = 5'($urandom); bus.CMD_WDATA = 8'($urandom);
        end else begin
            bus.CMD_VALID = 1'b0;
        end
        for (int c = 0; c < 60 && t_acc && !t_got; c++) begin
            t_lat++;
            if (bus.RSP_VALID === 1'b1) begin
                t_got = 1; t_rdata = bus.RSP_RDATA; t_err = bus.RSP_ERR;
            end else begin
                if (bus.PSEL === 1'b1) t_nsel++;
                if (bus.PENABLE === 1'b1) t_nen++;
                if (bus.PSEL === 1'b1 && (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== (wr ? wdata : 8'h00)))
                    t_bus_ok = 0;
                if (bus.PENABLE === 1'b1) begin
                    bus.PREADY = (acnt >= waits);
                    acnt++;
                end else begin
                    bus.PREADY = 1'b0;
                end
                bus.PRDATA = bus.PREADY ? prdata : 8'($urandom);
                @(posedge PCLK); @(negedge PCLK);
            end
        end
        bus.PREADY = 1'b0;
        if (t_got) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge PCLK); @(negedge PCLK);
                if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== t_rdata || bus.RSP_ERR !== t_err || bus.CMD_READY !== 1'b0 ||
                    bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.PADDR !== addr)
                    t_hold_ok = 0;
            end
            bus.RSP_READY = 1'b1;
            @(posedge PCLK); @(negedge PCLK);
            bus.RSP_READY = 1'b0;
            t_done_ok = (bus.CMD_READY === 1'b1 && bus.RSP_VALID === 1'b0 && bus.RSP_RDATA === t_rdata && bus.RSP_ERR === t_err);
        end
    endtask

    task automatic test_reset();
        @(negedge PCLK);
        checks++; if (bus.CMD_READY !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.CMD_READY); end
        checks++; if ({bus.RSP_VALID, bus.RSP_RDATA, bus.RSP_ERR, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== 27'd0)
            begin errors++; $display("FAIL reset_outputs: got %h expected 0", {bus.RSP_VALID, bus.RSP_RDATA, bus.RSP_ERR, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}); end
        checks++; if (bus0.CMD_READY !== 1'b1 || {bus0.RSP_VALID, bus0.PSEL, bus0.PENABLE} !== 3'd0)
            begin errors++; $display("FAIL reset_dut0: got ready=%b v/sel/en=%b expected 1/000", bus0.CMD_READY, {bus0.RSP_VALID, bus0.PSEL, bus0.PENABLE}); end
        PRESET = 1'b0;
        @(posedge PCLK); @(negedge PCLK);
        checks++; if (bus.CMD_READY !== 1'b1 || bus.PSEL !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready=%b psel=%b expected 1/0", bus.CMD_READY, bus.PSEL); end
    endtask

    task automatic test_write_zero_wait();
        int t0 = toggles;
        do_txn(1'b1, REG_STATUS_ADDR, 8'h01, 0, 8'($urandom), 0, 1'b0);
        checks++; if (!(t_acc && t_got)) begin errors++; $display("FAIL wr0_complete: got acc=%b rsp=%b expected 1/1", t_acc, t_got); end
        checks++; if (t_lat !== 3) begin errors++; $display("FAIL wr0_latency: got %0d expected 3", t_lat); end
        checks++; if (t_nsel !== 2 || t_nen !== 1) begin errors++; $display("FAIL wr0_psel_penable: got %0d/%0d expected 2/1", t_nsel, t_nen); end
        checks++; if (!t_bus_ok) begin errors++; $display("FAIL wr0_bus_fields: got bad expected stable addr/pwdata=01"); end
        checks++; if (t_err !== 1'b0 || t_rdata !== 8'h00) begin errors++; $display("FAIL wr0_rsp: got err=%b rdata=%h expected 0/00", t_err, t_rdata); end
        checks++; if (!t_done_ok) begin errors++; $display("FAIL wr0_handshake: got bad expected ready back"); end
        checks++; if (toggles !== t0 + 1) begin errors++; $display("FAIL wr0_status_toggle: got %0d expected %0d", toggles, t0 + 1); end
    endtask

    task automatic test_read_waits();
        do_txn(1'b0, 5'h03, 8'($urandom), 4, 8'hA5, 1, 1'b0);
        checks++; if (t_nen !== 5 || t_nsel !== 6) begin errors++; $display("FAIL rdw_penable: got en=%0d sel=%0d expected 5/6", t_nen, t_nsel); end
        checks++; if (!t_bus_ok || !t_hold_ok) begin errors++; $display("FAIL rdw_paddr_stable: got bus=%b hold=%b expected 1/1", t_bus_ok, t_hold_ok); end
        checks++; if (t_rdata !== 8'hA5 || t_err !== 1'b0) begin errors++; $display("FAIL rdw_rsp: got %h/%b expected a5/0", t_rdata, t_err); end
        checks++; if (t_lat !== 7) begin errors++; $display("FAIL rdw_latency: got %0d expected 7", t_lat); end
    endtask

    task automatic test_timeout();
        int wl [3] = '{100, 14, 15};
        for (int i = 0; i < 3; i++) begin
            logic [7:0] pd = 8'($urandom);
            logic [7:0] er = exp_err(wl[i]) ? 8'h00 : pd;
            do_txn(1'b0, 5'($urandom), 8'($urandom), wl[i], pd, 0, 1'b0);
            checks++; if (t_nen !== exp_access(wl[i])) begin errors++; $display("FAIL tmo_access_cycles w=%0d: got %0d expected %0d", wl[i], t_nen, exp_access(wl[i])); end
            checks++; if (t_err !== exp_err(wl[i]) || t_rdata !== er) begin errors++; $display("FAIL tmo_rsp w=%0d: got err=%b rdata=%h expected %b/%h", wl[i], t_err, t_rdata, exp_err(wl[i]), er); end
        end
    endtask

    task automatic test_back_to_back();
        do_txn(1'b1, 5'h01, 8'($urandom), 2, 8'h00, 6, 1'b1);
        checks++; if (!t_hold_ok || !t_done_ok) begin errors++; $display("FAIL b2b_backpressure: got hold=%b done=%b expected 1/1", t_hold_ok, t_done_ok); end
        do_txn(1'b0, 5'h02, 8'($urandom), 0, 8'h3C, 0, 1'b1);
        checks++; if (last_gap !== 9) begin errors++; $display("FAIL b2b_gap_after_hold: got %0d expected 9", last_gap); end
        checks++; if (t_rdata !== 8'h3C || !t_bus_ok) begin errors++; $display("FAIL b2b_second_rsp: got %h bus=%b expected 3c/1", t_rdata, t_bus_ok); end
        do_txn(1'b1, REG_STATUS_ADDR, 8'h01, 1, 8'h00, 0, 1'b0);
        checks++; if (last_gap !== 3) begin errors++; $display("FAIL b2b_min_gap: got %0d expected 3", last_gap); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit         wr = 1'($urandom);
            logic [4:0] ad = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
            logic [7:0] wd = 8'($urandom);
            logic [7:0] pd = 8'($urandom);
            int         w  = $urandom_range(0, 18);
            int         h  = $urandom_range(0, 3);
            int         t0 = toggles;
            int         et = (wr && ad == REG_STATUS_ADDR && wd[0]) ? 1 : 0;
            logic [7:0] er = (!wr && !exp_err(w)) ? pd : 8'h00;
            do_txn(wr, ad, wd, w, pd, h, 1'b0);
            checks++; if (t_lat !== exp_access(w) + 2 || t_nen !== exp_access(w)) begin errors++; $display("FAIL rnd%0d_timing: got lat=%0d en=%0d expected %0d/%0d", i, t_lat, t_nen, exp_access(w) + 2, exp_access(w)); end
            checks++; if (t_rdata !== er || t_err !== exp_err(w)) begin errors++; $display("FAIL rnd%0d_rsp: got %h/%b expected %h/%b", i, t_rdata, t_err, er, exp_err(w)); end
            checks++; if (!(t_bus_ok && t_hold_ok && t_done_ok)) begin errors++; $display("FAIL rnd%0d_protocol: got bus=%b hold=%b done=%b expected 111", i, t_bus_ok, t_hold_ok, t_done_ok); end
            checks++; if (toggles !== t0 + et) begin errors++; $display("FAIL rnd%0d_status_toggle: got %0d expected %0d", i, toggles, t0 + et); end
        end
    endtask

    task automatic test_reset_mid();
        bit quiet = 1;
        bus.CMD_VALID = 1'b1; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = 5'h07; bus.PREADY = 1'b0; bus.RSP_READY = 1'b0;
        @(posedge PCLK); @(negedge PCLK);
        bus.CMD_VALID = 1'b0;
        for (int c = 0; c < 10 && bus.PENABLE !== 1'b1; c++) begin @(posedge PCLK); @(negedge PCLK); end
        checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL rstmid_reach_access: got %b expected 1", bus.PENABLE); end
        #2 PRESET = 1'b1;
        #1;
        checks++; if ({bus.PSEL, bus.PENABLE, bus.RSP_VALID} !== 3'b000) begin errors++; $display("FAIL rstmid_async_drop: got %b expected 000", {bus.PSEL, bus.PENABLE, bus.RSP_VALID}); end
        checks++; if (bus.CMD_READY !== 1'b1 || bus.PADDR !== 5'h00) begin errors++; $display("FAIL rstmid_idle_values: got ready=%b paddr=%h expected 1/00", bus.CMD_READY, bus.PADDR); end
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge PCLK); @(negedge PCLK);
            if (bus.RSP_VALID !== 1'b0 || bus.CMD_READY !== 1'b1 || bus.PSEL !== 1'b0) quiet = 0;
        end
        checks++; if (!quiet) begin errors++; $display("FAIL rstmid_no_response: got activity expected idle"); end
    endtask

    task automatic test_timeout0();
        bit stuck = 1;
        logic [7:0] pd = 8'($urandom);
        bus0.CMD_VALID = 1'b1; bus0.CMD_WRITE = 1'b0; bus0.CMD_ADDR = 5'h05; bus0.PREADY = 1'b0; bus0.RSP_READY = 1'b0;
        @(posedge PCLK); @(negedge PCLK);
        bus0.CMD_VALID = 1'b0;
        for (int c = 0; c < 10 && bus0.PENABLE !== 1'b1; c++) begin @(posedge PCLK); @(negedge PCLK); end
        for (int c = 0; c < 100; c++) begin
            if (bus0.PENABLE !== 1'b1 || bus0.RSP_VALID !== 1'b0) stuck = 0;
            @(posedge PCLK); @(negedge PCLK);
        end
        checks++; if (!stuck) begin errors++; $display("FAIL tmo0_stays_access: got left ACCESS expected stay"); end
        bus0.PREADY = 1'b1; bus0.PRDATA = pd;
        @(posedge PCLK); @(negedge PCLK);
        bus0.PREADY = 1'b0;
        checks++; if (bus0.RSP_VALID !== 1'b1 || bus0.RSP_RDATA !== pd || bus0.RSP_ERR !== 1'b0)
            begin errors++; $display("FAIL tmo0_complete: got v=%b rdata=%h err=%b expected 1/%h/0", bus0.RSP_VALID, bus0.RSP_RDATA, bus0.RSP_ERR, pd); end
        bus0.RSP_READY = 1'b1;
        @(posedge PCLK); @(negedge PCLK);
        bus0.RSP_READY = 1'b0;
        checks++; if (bus0.CMD_READY !== 1'b1 || bus0.RSP_VALID !== 1'b0) begin errors++; $display("FAIL tmo0_handshake: got ready=%b v=%b expected 1/0", bus0.CMD_READY, bus0.RSP_VALID); end
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET = 1'b1;
        bus.CMD_VALID = 1'b0; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = '0; bus.CMD_WDATA = '0;
        bus.RSP_READY = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0;
        bus0.CMD_VALID = 1'b0; bus0.CMD_WRITE = 1'b0; bus0.CMD_ADDR = '0; bus0.CMD_WDATA = '0;
        bus0.RSP_READY = 1'b0; bus0.PRDATA = '0; bus0.PREADY = 1'b0;
        repeat (3) @(posedge PCLK);
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_timeout0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB requester (initiator) that drives the debugger's APB bus toward the register completers: status, control and memory-access windows.
- Accepts one command at a time from the debug transport (UART/SPI byte decoder) on a valid/ready channel.
- Runs a two-phase APB transfer (SETUP then ACCESS), waits for PREADY with a bounded timeout, and returns read data and an error flag on a valid/ready response channel.

Parameters:
- ADDR_W, 5, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT, 15, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; all state on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command accepted this cycle when high together with CMD_VALID.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_W  target address.
- CMD_WDATA  in  DATA_W  write data; ignored for reads.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed.
- RSP_RDATA  out  DATA_W  read data; 0 for writes and timeouts.
- RSP_ERR  out  1  1 = transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset value of every output is 0, except CMD_READY, which is 1 (IDLE). FSM resets to IDLE.
- PRESET asserted mid-transfer drops PSEL/PENABLE immediately (asynchronous) and discards any pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - CMD_READY = 1.
  - On CMD_VALID: register CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA, then go to SETUP.
  - For reads, PWDATA is loaded with 0.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0. Next state ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - If PREADY=1: capture PRDATA into RSP_RDATA for reads (0 for writes), set RSP_ERR=0, go to RESP.
  - Else increment the wait counter. When the counter reaches TIMEOUT with PREADY still low: RSP_RDATA=0, RSP_ERR=1, go to RESP.
  - Counter is cleared on entry to ACCESS and is $clog2(TIMEOUT+1) bits wide (minimum 1).
  - A PREADY sampled high on the same edge as the timeout wins, giving a normal completion.
- RESP:
  - PSEL=0, PENABLE=0, RSP_VALID=1.
  - RSP_RDATA/RSP_ERR held stable until RSP_READY, then go to IDLE.
  - RSP_RDATA/RSP_ERR keep their value after the handshake until the next response.
- PADDR/PWRITE/PWDATA stay stable from SETUP through the end of ACCESS and hold their value in RESP/IDLE. They change only on command acceptance.
- Latency, zero-wait completer with RSP_READY tied high: CMD accepted at edge N, SETUP N+1, ACCESS N+2, RSP_VALID high in cycle N+3, next CMD_READY in cycle N+4.
- PENABLE is low for at least 3 consecutive cycles between transfers (RESP, IDLE, SETUP). This is mandatory: completers detect the PENABLE rising edge and act once per transfer.
- Only one transfer is outstanding. No command is accepted while RSP_VALID is high.
- CMD_* values are don't-care when CMD_VALID is low.

Decomposition:
- Shared debugger package: FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3), default APB ADDR_W/DATA_W constants, and debugger register address constants (status register = 5'h00).
- One natural sub-module: apb_wait_timer. It holds the clearable wait counter with a TIMEOUT-reached flag and a disable-on-zero parameter.
- The FSM and datapath registers stay in apb_requester.

Test Plan:
- Write, zero-wait: CMD write addr 5'h00 data 8'h01, PREADY tied 1 -> PSEL high 2 cycles, PENABLE high 1 cycle, PWDATA=8'h01; RSP_VALID 3 cycles after accept with RSP_ERR=0, RSP_RDATA=0.
- Read with waits: CMD read addr 5'h03, PREADY low 4 ACCESS cycles then high with PRDATA=8'hA5 -> PENABLE high 5 cycles, PADDR stable at 5'h03, RSP_RDATA=8'hA5, RSP_ERR=0.
- Timeout: TIMEOUT=15, PREADY held 0 -> PENABLE drops after exactly 15 ACCESS cycles; RSP_ERR=1, RSP_RDATA=0. Repeat with PREADY rising on cycle 15 -> RSP_ERR=0.
- Back-pressure and back-to-back:
  - Hold RSP_READY=0 for 6 cycles with CMD_VALID continuously high -> CMD_READY stays 0, RSP fields stable, PSEL/PENABLE stay 0.
  - Release RSP_READY -> next command starts with ≥3 PENABLE-low cycles.
  - Against a status-register completer model, a write of 8'h01 toggles the debug-request bit exactly once.
- Reset mid-operation: assert PRESET asynchronously during ACCESS -> PSEL/PENABLE/RSP_VALID go 0 without waiting for a clock edge, CMD_READY=1 after release, no response emitted.
- TIMEOUT=0 build: PREADY low 100 cycles -> transfer stays in ACCESS; PREADY high -> normal completion.
